// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Control-phase sequencer for the MU0 CPU. It produces one-hot FETCH / EXEC1 /
// EXEC2 phase strobes for cpu_decoder and sizes each instruction from its
// opcode: LDA/ADD/SUB (0x0, 0x2, 0x3) take three cycles and every other legal
// opcode takes two. The block also handles run/halt control, STP (0x7) and
// illegal-opcode (0xB-0xF) trapping, and keeps a retired-instruction counter
// for debug.
//
// Optional feature (off by default):
//   CPU_SEQUENCER_SINGLE_STEP_EN - adds STEP_MODE and STEP inputs. With
//   STEP_MODE=1 the core returns to IDLE after every instruction, and a STEP
//   pulse in IDLE starts the next one, exactly as RUN does.
//
// Parameters:
//   CNT_W      width of the retired-instruction counter INSTR_CNT
//
// Ports:
//   CLK        system clock, rising edge
//   RESET_N    asynchronous active-low reset
//   OP         IR[15:12]; valid from the first EXEC1 cycle, stable through EXEC2
//   RUN        start/resume request, level-sampled in IDLE
//   HALT_REQ   stop request, honoured at instruction boundaries and in IDLE
//   STEP_MODE  (optional) return to IDLE after each instruction
//   STEP       (optional) start one instruction from IDLE
//   FETCH      fetch phase strobe
//   EXEC1      execute phase 1 strobe
//   EXEC2      execute phase 2 strobe
//   IR_LOAD    load IR at the end of this cycle (same as FETCH)
//   HALTED     core stopped by STP or an illegal opcode
//   ILLEGAL    sticky flag: the stop was caused by an illegal opcode
//   INSTR_CNT  retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [3:0]       OP,
  input  logic             RUN,
  input  logic             HALT_REQ,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  input  logic             STEP_MODE,
  input  logic             STEP,
`endif
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             IR_LOAD,
  output logic             HALTED,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Start and single-step qualifiers. Without the step feature the core
  // behaves as if STEP_MODE were tied low.
  logic start_req;
  logic step_mode;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
  assign start_req = RUN | STEP;
  assign step_mode = STEP_MODE;
`else
  assign start_req = RUN;
  assign step_mode = 1'b0;
`endif

  // Where to go after the final phase of a legal instruction.
  state_e boundary_next;
  assign boundary_next = (HALT_REQ || step_mode) ? S_IDLE : S_FETCH;

  // ---------------------------------------------------------------------------
  // Next-state and register-update logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_req && !HALT_REQ) state_d = S_FETCH;
      end

      S_FETCH: begin
        state_d = S_EXEC1;
      end

      S_EXEC1: begin
        case (OP)
          4'h0, 4'h2, 4'h3: begin
            state_d = S_EXEC2;
          end
          4'h7: begin
            // STP retires, then stops the core.
            state_d = S_HALT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
          4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
            // Illegal opcodes trap without retiring.
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default: begin
            state_d = boundary_next;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        endcase
      end

      S_EXEC2: begin
        state_d = boundary_next;
        cnt_d   = cnt_q + CNT_W'(1);
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only
  // ---------------------------------------------------------------------------
  assign FETCH     = (state_q == S_FETCH);
  assign EXEC1     = (state_q == S_EXEC1);
  assign EXEC2     = (state_q == S_EXEC2);
  assign IR_LOAD   = FETCH;
  assign HALTED    = (state_q == S_HALT);
  assign ILLEGAL   = illegal_q;
  assign INSTR_CNT = cnt_q;

endmodule
